// File: rtl/pid_pkg.sv
// Shared definitions for the PID controller and its plant model:
// FSM state encoding, data width and measurement saturation bounds.
package pid_pkg;
  localparam int DATA_W  = 16;
  localparam int SAT_MIN = 0;
  localparam int SAT_MAX = 65535;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    UPDATE = 3'd4
  } pid_state_e;
endpackage

// File: rtl/pid_sat16.sv
// Clamp an 18-bit signed intermediate into the 16-bit unsigned data range.
module pid_sat16
  import pid_pkg::*;
(
  input  logic signed [17:0]       din_i,
  output logic        [DATA_W-1:0] dout_o
);
  localparam logic signed [17:0] LO = 18'(SAT_MIN);
  localparam logic signed [17:0] HI = 18'(SAT_MAX);

  always_comb begin
    dout_o = din_i[DATA_W-1:0];
    if (din_i < LO)      dout_o = DATA_W'(SAT_MIN);
    else if (din_i > HI) dout_o = DATA_W'(SAT_MAX);
  end
endmodule

// File: rtl/pid_plant_model.sv
// First-order plant model that periodically requests a PID output and filters it into meas_out.
// Define PLANT_DIST_EN to add a signed disturbance_in input summed into each update.
module pid_plant_model
  import pid_pkg::*;
#(
  parameter int unsigned       SAMPLE_DIV  = 64,
  parameter int unsigned       RESP_WAIT   = 6,
  parameter int unsigned       ALPHA_SHIFT = 3,
  parameter logic [DATA_W-1:0] INIT_MEAS   = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic        [DATA_W-1:0] ctrl_in,
`ifdef PLANT_DIST_EN
  input  logic signed [DATA_W-1:0] disturbance_in,
`endif
  output logic        [DATA_W-1:0] meas_out,
  output logic                     pid_start,
  output logic                     sample_valid
);
  localparam logic [15:0] DIV_LAST  = 16'(SAMPLE_DIV - 1);
  localparam logic [7:0]  WAIT_LAST = 8'(RESP_WAIT);

  pid_state_e        state_q, state_d;
  logic [15:0]       div_q, div_d;
  logic [7:0]        wait_q, wait_d;
  logic [DATA_W-1:0] u_q, u_d;
  logic [DATA_W-1:0] meas_q, meas_d;

  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [17:0] ynew;
  logic [DATA_W-1:0]  ysat;

  always_comb begin
    diff = $signed({1'b0, u_q}) - $signed({1'b0, meas_q});
    step = diff >>> ALPHA_SHIFT;
    ynew = $signed({2'b00, meas_q}) + $signed({step[16], step});
`ifdef PLANT_DIST_EN
    ynew = ynew + $signed({{2{disturbance_in[DATA_W-1]}}, disturbance_in});
`endif
  end

  pid_sat16 u_sat (
    .din_i  (ynew),
    .dout_o (ysat)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    wait_d  = wait_q;
    u_d     = u_q;
    meas_d  = meas_q;
    unique case (state_q)
      IDLE: begin
        div_d  = '0;
        wait_d = '0;
        if (enable) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          state_d = START;
          div_d   = '0;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      START: begin
        // The START cycle counts as the first cycle of the response wait.
        wait_d  = wait_q + 8'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          u_d     = ctrl_in;
          wait_d  = '0;
          state_d = UPDATE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      UPDATE: begin
        meas_d  = ysat;
        state_d = enable ? COUNT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      wait_q  <= '0;
      u_q     <= '0;
      meas_q  <= INIT_MEAS;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wait_q  <= wait_d;
      u_q     <= u_d;
      meas_q  <= meas_d;
    end
  end

  // New value is presented during UPDATE itself so it coincides with sample_valid.
  assign meas_out     = (state_q == UPDATE) ? ysat : meas_q;
  assign pid_start    = (state_q == START);
  assign sample_valid = (state_q == UPDATE);
endmodule

// File: tb/tb_pid_plant_model.sv
// Directed bench for pid_plant_model with a small reference model of the plant update.
module tb_pid_plant_model;
  localparam int SD = 4;
  localparam int RW = 6;
  localparam int AS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] ctrl_in;
  logic [15:0] meas_out;
  logic        pid_start;
  logic        sample_valid;
`ifdef PLANT_DIST_EN
  logic signed [15:0] dist;
`endif

  int checks = 0;
  int passes = 0;
  int y_ref  = 0;

  always #5 clk = ~clk;

  pid_plant_model #(
    .SAMPLE_DIV  (SD),
    .RESP_WAIT   (RW),
    .ALPHA_SHIFT (AS),
    .INIT_MEAS   (16'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .ctrl_in        (ctrl_in),
`ifdef PLANT_DIST_EN
    .disturbance_in (dist),
`endif
    .meas_out       (meas_out),
    .pid_start      (pid_start),
    .sample_valid   (sample_valid)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    chk("start_valid_exclusive", int'(pid_start & sample_valid), 0);
  endtask

  task automatic wait_pid(input int bound, output int n);
    n = 0;
    do begin step(); n++; end while (!pid_start && n < bound);
    if (!pid_start) n = -1;
  endtask

  task automatic wait_sv(input int bound, output int n);
    n = 0;
    do begin step(); n++; end while (!sample_valid && n < bound);
    if (!sample_valid) n = -1;
  endtask

  function automatic int model(input int y, input int u, input int d);
    int diff, st, r;
    diff = u - y;
    st   = (diff >= 0) ? diff / (1 << AS) : -((-diff + (1 << AS) - 1) / (1 << AS));
    r    = y + st + d;
    if (r < 0) r = 0;
    if (r > 65535) r = 65535;
    return r;
  endfunction

  // One full sample: expects START SD+1 cycles after the current point, then UPDATE RW+1 later.
  task automatic sample(input string tag, input int u, input int d, input int exp_y);
    int n;
    wait_pid(50, n);
    chk({tag, "_start_gap"}, n, SD + 1);
    chk({tag, "_meas_stable"}, int'(meas_out), y_ref);
    ctrl_in = 16'(u);
`ifdef PLANT_DIST_EN
    dist = 16'(d);
`endif
    wait_sv(50, n);
    chk({tag, "_valid_lat"}, n, RW + 1);
    chk({tag, "_meas"}, int'(meas_out), exp_y);
    y_ref = exp_y;
  endtask

  initial begin
    int n, cnt, prev;
    rst_n   = 1'b0;
    enable  = 1'b0;
    ctrl_in = '0;
`ifdef PLANT_DIST_EN
    dist    = '0;
`endif
    #1;
    chk("rst_meas", int'(meas_out), 0);
    chk("rst_pid_start", int'(pid_start), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    enable = 1'b1;

    sample("y0_u800", 800, 0, 100);
    sample("y100_u7300", 7300, 0, 1000);
    sample("y1000_u200", 200, 0, 900);

    // Drop enable mid-WAIT: sample must still complete, then idle.
    wait_pid(50, n);
    chk("drop_start_gap", n, SD + 1);
    ctrl_in = 16'd900;
    step(); step();
    enable = 1'b0;
    wait_sv(50, n);
    chk("drop_valid_lat", n + 2, RW + 1);
    chk("drop_meas", int'(meas_out), 900);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pid_start) cnt++;
    end
    chk("drop_no_more_start", cnt, 0);

    // Reset during WAIT discards the sample.
    enable = 1'b1;
    wait_pid(50, n);
    chk("rst_run_start_gap", n, SD + 1);
    ctrl_in = 16'd4000;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_meas", int'(meas_out), 0);
    chk("midrst_pid_start", int'(pid_start), 0);
    chk("midrst_sample_valid", int'(sample_valid), 0);
    enable = 1'b0;
    step(); step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sample_valid || pid_start) cnt++;
    end
    chk("midrst_no_activity", cnt, 0);
    chk("midrst_meas_held", int'(meas_out), 0);
    y_ref  = 0;
    enable = 1'b1;

    sample("y0_u40", 40, 0, 5);
    sample("y5_u4_floor", 4, 0, 4);

    // Constant drive toward 54321 as a stand-in for the controller output.
    for (int i = 0; i < 200; i++) begin
      prev = y_ref;
      sample("loop", 54321, 0, model(y_ref, 54321, 0));
      chk("loop_monotonic", int'(int'(meas_out) >= prev), 1);
    end

`ifdef PLANT_DIST_EN
    sample("dist_hi_a", 65535, 32767, model(y_ref, 65535, 32767));
    sample("dist_hi_b", 65535, 100, 65535);
    sample("dist_lo_a", 0, -32768, model(y_ref, 0, -32768));
    sample("dist_lo_b", 0, -32768, model(y_ref, 0, -32768));
    sample("dist_lo_c", 10, -50, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
